// File: rtl/b06_trace_pkg.sv
// Shared types and helpers for the b06 output trace monitor.
package b06_trace_pkg;

    // Width of one sampled b06 output vector.
    localparam int SNAP_W = 6;

    // One sample of the four b06 outputs, MSB first as it appears in an event.
    typedef struct packed {
        logic [1:0] cc_mux;
        logic [1:0] uscite;
        logic       enable_count;
        logic       ackout;
    } snapshot_t;

    // Monitor state: IDLE until the first sampled cycle, RUN forever after.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mon_state_t;

    // Pack the raw b06 outputs into the snapshot field of an event.
    function automatic snapshot_t make_snap(
        input logic [1:0] cc_mux,
        input logic [1:0] uscite,
        input logic       enable_count,
        input logic       ackout
    );
        snapshot_t s;
        s.cc_mux       = cc_mux;
        s.uscite       = uscite;
        s.enable_count = enable_count;
        s.ackout       = ackout;
        return s;
    endfunction

endpackage

// File: rtl/b06_trace_monitor_fifo.sv
// Synchronous first-word-fall-through FIFO holding trace events.
// Extra-bit pointers distinguish full from empty; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Occupancy flags derived from the registered pointers.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        level   = wr_ptr - rd_ptr;
        do_pop  = pop && !empty;
        do_push = push && (!full || pop);
    end

    // Pointer update on accepted push and pop.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents clear on reset so the head reads zero when empty.
    // NOTE: this memory is reset on purpose (small, and reset must wipe in-flight entries);
    // large RAMs normally stay unreset so they can map to memory macros.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Fall-through read at the registered read pointer.
    assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/b06_trace_monitor.sv
// Output trace monitor for the b06 core under concolic replay.
// Samples the four b06 outputs when sample_en is high, logs a timestamped
// event on every change (plus the first sample and every timestamp wrap),
// and queues events in a FIFO drained through a valid/ready port.
module b06_trace_monitor
    import b06_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sample_en,
    input  logic [1:0]               cc_mux,
    input  logic [1:0]               uscite,
    input  logic                     enable_count,
    input  logic                     ackout,
    output logic                     ev_valid,
    output logic [TS_W+SNAP_W:0]     ev_data,
    input  logic                     ev_ready,
    input  logic                     clr,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int EV_W = TS_W + SNAP_W + 1;

    mon_state_t      state_q;
    logic [TS_W-1:0] ts_q;
    snapshot_t       prev_q;
    snapshot_t       snap;

    logic            ev_push;
    logic            ev_wrap;
    logic [EV_W-1:0] ev_word;
    logic            fifo_full;
    logic            fifo_empty;
    logic            ev_pop;
    logic            drop;

    // Event detection: first sample in IDLE, then change or timestamp wrap in RUN.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        snap    = make_snap(cc_mux, uscite, enable_count, ackout);
        ev_push = 1'b0;
        ev_wrap = 1'b0;
        if (sample_en) begin
            if (state_q == IDLE) begin
                ev_push = 1'b1;
            end else begin
                ev_wrap = (ts_q == '0);
                ev_push = (snap != prev_q) || ev_wrap;
            end
        end
        ev_word  = {ev_wrap, ts_q, snap};
        ev_valid = !fifo_empty;
        ev_pop   = ev_valid && ev_ready;
        drop     = ev_push && fifo_full && !ev_pop;
    end

    // Monitor state, timestamp and previous sample advance only on sampled cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ts_q    <= '0;
            prev_q  <= '0;
        end else if (sample_en) begin
            state_q <= RUN;
            ts_q    <= ts_q + 1'b1;
            prev_q  <= snap;
        end
    end

    // Drop accounting; a drop in the same cycle as clr takes priority.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            if (clr)                      drop_count <= 8'd1;
            else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end else if (clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (ev_push),
        .push_data (ev_word),
        .pop       (ev_pop),
        .pop_data  (ev_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

endmodule

// File: tb/tb_b06_trace_monitor.sv
// Directed bench for b06_trace_monitor: a default instance (TS_W=16) and a
// narrow-timestamp instance (TS_W=4) share stimulus; each task checks one feature.
module tb_b06_trace_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        sample_en;
    logic [1:0]  cc_mux;
    logic [1:0]  uscite;
    logic        enable_count;
    logic        ackout;
    logic        ev_ready;
    logic        clr;

    logic        ev_valid;
    logic [22:0] ev_data;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [4:0]  level;

    logic        ev_valid4;
    logic [10:0] ev_data4;
    logic        overflow4;
    logic [7:0]  drop_count4;
    logic [4:0]  level4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    b06_trace_monitor #(.DEPTH(16), .TS_W(16)) u_dut (
        .clock        (clock),
        .reset        (reset),
        .sample_en    (sample_en),
        .cc_mux       (cc_mux),
        .uscite       (uscite),
        .enable_count (enable_count),
        .ackout       (ackout),
        .ev_valid     (ev_valid),
        .ev_data      (ev_data),
        .ev_ready     (ev_ready),
        .clr          (clr),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .level        (level)
    );

    b06_trace_monitor #(.DEPTH(16), .TS_W(4)) u_dut4 (
        .clock        (clock),
        .reset        (reset),
        .sample_en    (sample_en),
        .cc_mux       (cc_mux),
        .uscite       (uscite),
        .enable_count (enable_count),
        .ackout       (ackout),
        .ev_valid     (ev_valid4),
        .ev_data      (ev_data4),
        .ev_ready     (ev_ready),
        .clr          (clr),
        .overflow     (overflow4),
        .drop_count   (drop_count4),
        .level        (level4)
    );

    task automatic set_snap(input logic [5:0] s);
        {cc_mux, uscite, enable_count, ackout} = s;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        sample_en = 1'b0;
        ev_ready  = 1'b0;
        clr       = 1'b0;
        set_snap(6'd0);
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        sample_en = 1'b0;
        ev_ready  = 1'b0;
        clr       = 1'b0;
        set_snap(6'd0);
        step();
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ev_valid got=%b exp=0", ev_valid); end
        n_cmp++; if (ev_data !== 23'd0) begin n_bad++; $display("FAIL reset_ev_data got=%h exp=0", ev_data); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_cmp++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        step();
        reset = 1'b1;
    endtask

    task automatic test_constant_snap();
        do_reset();
        sample_en = 1'b1;
        set_snap(6'd0);
        step();
        n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL const_first_level got=%0d exp=1", level); end
        repeat (9) step();
        n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL const_level_after10 got=%0d exp=1", level); end
        n_cmp++; if (ev_valid !== 1'b1) begin n_bad++; $display("FAIL const_ev_valid got=%b exp=1", ev_valid); end
        n_cmp++; if (ev_data !== 23'd0) begin n_bad++; $display("FAIL const_ev_data got=%h exp=0", ev_data); end
        sample_en = 1'b0;
        ev_ready  = 1'b1;
        step();
        ev_ready = 1'b0;
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL const_drain_level got=%0d exp=0", level); end
    endtask

    task automatic test_toggle();
        logic        exp_v;
        logic        exp_ack;
        logic [22:0] exp_d;
        do_reset();
        ev_ready  = 1'b1;
        sample_en = 1'b1;
        for (int c = 0; c < 9; c++) begin
            exp_ack = (c >= 3 && c < 5);
            exp_v   = (c == 0 || c == 3 || c == 5);
            set_snap({5'b00000, exp_ack});
            step();
            exp_d = {1'b0, c[15:0], 5'b00000, exp_ack};
            n_cmp++; if (ev_valid !== exp_v) begin n_bad++; $display("FAIL toggle_valid cyc=%0d got=%b exp=%b", c, ev_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (ev_data !== exp_d) begin n_bad++; $display("FAIL toggle_data cyc=%0d got=%h exp=%h", c, ev_data, exp_d); end
            end
        end
        sample_en = 1'b0;
        ev_ready  = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        ev_ready  = 1'b0;
        sample_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_snap(6'(i + 1));
            step();
        end
        sample_en = 1'b0;
        n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL ovf_level got=%0d exp=16", level); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        n_cmp++; if (drop_count !== 8'd4) begin n_bad++; $display("FAIL ovf_drop_count got=%0d exp=4", drop_count); end
        n_cmp++; if (ev_data !== 23'd1) begin n_bad++; $display("FAIL ovf_head got=%h exp=%h", ev_data, 23'd1); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clr_overflow got=%b exp=0", overflow); end
        n_cmp++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL clr_drop_count got=%0d exp=0", drop_count); end
        n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL clr_level got=%0d exp=16", level); end
    endtask

    // Continues from the full FIFO left by test_overflow.
    task automatic test_full_pop();
        sample_en = 1'b1;
        ev_ready  = 1'b1;
        set_snap(6'd40);
        step();
        sample_en = 1'b0;
        ev_ready  = 1'b0;
        n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL fullpop_level got=%0d exp=16", level); end
        n_cmp++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL fullpop_drop_count got=%0d exp=0", drop_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fullpop_overflow got=%b exp=0", overflow); end
        n_cmp++; if (ev_data !== {1'b0, 16'd1, 6'd2}) begin n_bad++; $display("FAIL fullpop_head got=%h exp=%h", ev_data, {1'b0, 16'd1, 6'd2}); end
    endtask

    // Continues from the still-full FIFO; clr coinciding with a drop.
    task automatic test_clr_vs_drop();
        sample_en = 1'b1;
        set_snap(6'd41);
        step();
        n_cmp++; if (drop_count !== 8'd1) begin n_bad++; $display("FAIL drop_single got=%0d exp=1", drop_count); end
        set_snap(6'd42);
        clr = 1'b1;
        step();
        clr       = 1'b0;
        sample_en = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL clrdrop_overflow got=%b exp=1", overflow); end
        n_cmp++; if (drop_count !== 8'd1) begin n_bad++; $display("FAIL clrdrop_count got=%0d exp=1", drop_count); end
        n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL clrdrop_level got=%0d exp=16", level); end
    endtask

    task automatic test_wrap();
        do_reset();
        sample_en = 1'b1;
        set_snap(6'd0);
        repeat (20) step();
        sample_en = 1'b0;
        n_cmp++; if (level4 !== 5'd2) begin n_bad++; $display("FAIL wrap_level got=%0d exp=2", level4); end
        n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL wrap_wide_level got=%0d exp=1", level); end
        n_cmp++; if (ev_data4 !== 11'h000) begin n_bad++; $display("FAIL wrap_first got=%h exp=000", ev_data4); end
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        n_cmp++; if (level4 !== 5'd1) begin n_bad++; $display("FAIL wrap_level_after_pop got=%0d exp=1", level4); end
        n_cmp++; if (ev_data4 !== 11'h400) begin n_bad++; $display("FAIL wrap_event got=%h exp=400", ev_data4); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ev_ready  = 1'b0;
        sample_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_snap(6'(i + 10));
            step();
        end
        n_cmp++; if (level !== 5'd5) begin n_bad++; $display("FAIL mid_level_before got=%0d exp=5", level); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL mid_level_async got=%0d exp=0", level); end
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid_async got=%b exp=0", ev_valid); end
        n_cmp++; if (ev_data !== 23'd0) begin n_bad++; $display("FAIL mid_data_async got=%h exp=0", ev_data); end
        sample_en = 1'b0;
        step();
        reset = 1'b1;
        sample_en = 1'b1;
        set_snap(6'h15);
        step();
        n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL mid_restart_level got=%0d exp=1", level); end
        n_cmp++; if (ev_data !== 23'h000015) begin n_bad++; $display("FAIL mid_restart_data got=%h exp=000015", ev_data); end
        n_cmp++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL mid_drop_count got=%0d exp=0", drop_count); end
        step();
        n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL mid_nochange_level got=%0d exp=1", level); end
    endtask

    // Continues from test_reset_mid: ts is 2, one entry (ts=0) queued.
    task automatic test_back_to_back();
        logic [22:0] exp_d;
        ev_ready  = 1'b1;
        sample_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_snap(6'(i + 30));
            step();
            exp_d = {1'b0, 16'(i + 2), 6'(i + 30)};
            n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL b2b_level i=%0d got=%0d exp=1", i, level); end
            n_cmp++; if (ev_data !== exp_d) begin n_bad++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, ev_data, exp_d); end
        end
        sample_en = 1'b0;
        step();
        ev_ready = 1'b0;
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL b2b_drain got=%0d exp=0", level); end
    endtask

    initial begin
        test_reset();
        test_constant_snap();
        test_toggle();
        test_overflow();
        test_full_pop();
        test_clr_vs_drop();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
